// File: rtl/pc_source_if.sv
// Control-unit-to-PC-source bus: datapath sources, write/branch/exception
// controls in one direction, registered PC/EPC/status back.
interface pc_source_if #(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 4,
    parameter int SEL_W  = 3
);
    logic [N_SRC*DATA_W-1:0] src_in;
    logic [SEL_W-1:0]        pc_src_sel;
    logic                    pc_write;
    logic                    pc_write_cond;
    logic [1:0]              branch_mode;
    logic                    alu_zero;
    logic                    alu_gt;
    logic                    exc_req;
    logic [1:0]              exc_code;
    logic [DATA_W-1:0]       pc_out;
    logic [DATA_W-1:0]       epc_out;
    logic                    exc_busy;
    logic                    sel_err;

    modport master (
        output src_in, pc_src_sel, pc_write, pc_write_cond, branch_mode,
               alu_zero, alu_gt, exc_req, exc_code,
        input  pc_out, epc_out, exc_busy, sel_err
    );

    modport slave (
        input  src_in, pc_src_sel, pc_write, pc_write_cond, branch_mode,
               alu_zero, alu_gt, exc_req, exc_code,
        output pc_out, epc_out, exc_busy, sel_err
    );
endinterface

// File: rtl/pc_source_unit.sv
// Next-PC source selection, branch-qualified PC write and the two-step
// exception sequence (save EPC, then vector PC) for the multicycle datapath.
module pc_source_unit #(
    parameter int                 DATA_W   = 32,
    parameter int                 N_SRC    = 4,
    parameter int                 SEL_W    = 3,
    parameter logic [DATA_W-1:0]  RESET_PC = {DATA_W{1'b0}},
    parameter logic [DATA_W-1:0]  EXC_BASE = DATA_W'(32'h0000_00FD),
    parameter int                 EPC_ADJ  = 4
) (
    input  logic       clk,
    input  logic       reset,
    pc_source_if.slave bus
);

    localparam int N_SLOT = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SAVE = 2'b01,
        VECT = 2'b10
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] pc_r;
    logic [DATA_W-1:0] epc_r;
    logic [1:0]        code_r;
    logic              busy_r;
    logic              sel_err_r;

    logic [DATA_W-1:0] slot_s [N_SLOT];
    logic [DATA_W-1:0] nxt_s;
    logic              sel_ok_s;
    logic              cond_s;
    logic              we_s;

    // Every select code gets a slot so the mux index is full width; illegal
    // slots feed the current PC, which is never loaded because sel_ok_s is low.
    genvar g;
    for (g = 0; g < N_SLOT; g++) begin : g_slot
        if (g < N_SRC) begin : g_ext
            assign slot_s[g] = bus.src_in[g*DATA_W +: DATA_W];
        end else if (g == N_SRC) begin : g_epc
            assign slot_s[g] = epc_r;
        end else begin : g_ill
            assign slot_s[g] = pc_r;
        end
    end

    // Next-PC mux, select legality, branch condition and write enable.
    always_comb begin
        nxt_s    = slot_s[bus.pc_src_sel];
        sel_ok_s = (bus.pc_src_sel <= SEL_W'(N_SRC));
        case (bus.branch_mode)
            2'b00:   cond_s = bus.alu_zero;
            2'b01:   cond_s = ~bus.alu_zero;
            2'b10:   cond_s = bus.alu_gt;
            2'b11:   cond_s = ~bus.alu_gt;
            default: cond_s = 1'b0;
        endcase
        we_s = bus.pc_write | (bus.pc_write_cond & cond_s);
    end

    // Exception sequencer and PC/EPC registers; exceptions beat PC writes in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            pc_r      <= RESET_PC;
            epc_r     <= {DATA_W{1'b0}};
            code_r    <= 2'b00;
            busy_r    <= 1'b0;
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.exc_req) begin
                        code_r  <= bus.exc_code;
                        busy_r  <= 1'b1;
                        state_r <= SAVE;
                    end else if (we_s && sel_ok_s) begin
                        pc_r <= nxt_s;
                    end else if (we_s) begin
                        sel_err_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SAVE: begin
                    // PC has already been incremented past the faulting instruction.
                    epc_r   <= pc_r - DATA_W'(EPC_ADJ);
                    busy_r  <= 1'b1;
                    state_r <= VECT;
                end
                VECT: begin
                    pc_r    <= EXC_BASE + DATA_W'(code_r);
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.pc_out   = pc_r;
    assign bus.epc_out  = epc_r;
    assign bus.exc_busy = busy_r;
    assign bus.sel_err  = sel_err_r;

endmodule

// File: tb/tb_pc_source_unit.sv
// Self-checking bench for pc_source_unit: directed scenarios plus random
// stimulus, all compared against a behavioural model of the PC/EPC rules.
module tb_pc_source_unit;

    logic clk;
    logic reset;

    pc_source_if #(.DATA_W(32), .N_SRC(4), .SEL_W(3)) bus ();

    pc_source_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] src_s [4];

    // Behavioural model state; exc_left counts the exception steps still pending.
    logic [31:0] exp_pc_r;
    logic [31:0] exp_epc_r;
    logic        exp_busy_r;
    logic        exp_serr_r;
    logic [1:0]  exp_code_r;
    int          exc_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void load_src();
        bus.src_in = {src_s[3], src_s[2], src_s[1], src_s[0]};
    endfunction

    // Apply the documented rules to the model for one clock edge.
    task automatic model_edge();
        logic cond;
        logic we;
        if (reset) begin
            exp_pc_r = 32'h0; exp_epc_r = 32'h0; exp_busy_r = 1'b0;
            exp_serr_r = 1'b0; exp_code_r = 2'd0; exc_left = 0;
        end else begin
            exp_serr_r = 1'b0;
            if (exc_left == 2) begin
                exp_epc_r  = exp_pc_r - 32'd4;
                exc_left   = 1;
                exp_busy_r = 1'b1;
            end else if (exc_left == 1) begin
                exp_pc_r   = 32'hFD + {30'd0, exp_code_r};
                exc_left   = 0;
                exp_busy_r = 1'b0;
            end else if (bus.exc_req) begin
                exp_code_r = bus.exc_code;
                exc_left   = 2;
                exp_busy_r = 1'b1;
            end else begin
                cond = (bus.branch_mode == 2'd0) ?  bus.alu_zero :
                       (bus.branch_mode == 2'd1) ? !bus.alu_zero :
                       (bus.branch_mode == 2'd2) ?  bus.alu_gt : !bus.alu_gt;
                we = bus.pc_write || (bus.pc_write_cond && cond);
                if (we) begin
                    if (bus.pc_src_sel < 3'd4)       exp_pc_r = src_s[bus.pc_src_sel[1:0]];
                    else if (bus.pc_src_sel == 3'd4) exp_pc_r = exp_epc_r;
                    else                             exp_serr_r = 1'b1;
                end
            end
        end
    endtask

    // One clock: model at the rising edge, compare all outputs on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("pc_out",   bus.pc_out,            exp_pc_r);
        check("epc_out",  bus.epc_out,           exp_epc_r);
        check("exc_busy", {31'd0, bus.exc_busy}, {31'd0, exp_busy_r});
        check("sel_err",  {31'd0, bus.sel_err},  {31'd0, exp_serr_r});
    endtask

    initial begin
        exp_pc_r = 32'h0; exp_epc_r = 32'h0; exp_busy_r = 1'b0;
        exp_serr_r = 1'b0; exp_code_r = 2'd0; exc_left = 0;
        src_s[0] = 32'h11; src_s[1] = 32'h22; src_s[2] = 32'h33; src_s[3] = 32'h44;
        load_src();
        bus.pc_src_sel = 3'd0; bus.pc_write = 1'b1; bus.pc_write_cond = 1'b1;
        bus.branch_mode = 2'd0; bus.alu_zero = 1'b1; bus.alu_gt = 1'b0;
        bus.exc_req = 1'b0; bus.exc_code = 2'd0;
        reset = 1'b1;
        @(negedge clk);

        // T1: reset wins over active writes
        step();
        check("t1_pc", bus.pc_out, 32'h0);
        check("t1_busy", {31'd0, bus.exc_busy}, 32'd0);
        reset = 1'b0;
        bus.pc_write_cond = 1'b0;

        // T2: select sweep then illegal select
        src_s[0] = 32'h8; src_s[1] = 32'h10; src_s[2] = 32'h20; src_s[3] = 32'h30;
        load_src();
        for (int s = 0; s < 4; s++) begin
            bus.pc_src_sel = 3'(s);
            step();
            check("t2_sweep", bus.pc_out, src_s[s]);
        end
        bus.pc_src_sel = 3'd5;
        step();
        check("t2_hold", bus.pc_out, 32'h30);
        check("t2_selerr", {31'd0, bus.sel_err}, 32'd1);
        bus.pc_write = 1'b0;
        step();
        check("t2_selerr_clr", {31'd0, bus.sel_err}, 32'd0);

        // T3: conditional writes
        bus.pc_write_cond = 1'b1; bus.branch_mode = 2'd0; bus.alu_zero = 1'b0;
        bus.pc_src_sel = 3'd1;
        step();
        check("t3_beq_hold", bus.pc_out, 32'h30);
        bus.alu_zero = 1'b1;
        step();
        check("t3_beq_load", bus.pc_out, 32'h10);
        bus.branch_mode = 2'd3; bus.alu_gt = 1'b1; bus.pc_src_sel = 3'd2;
        step();
        check("t3_ble_hold", bus.pc_out, 32'h10);
        bus.alu_gt = 1'b0;
        step();
        check("t3_ble_load", bus.pc_out, 32'h20);
        bus.pc_write_cond = 1'b0;

        // T4: exception with a competing write, writes ignored while busy
        src_s[0] = 32'h104; load_src();
        bus.pc_src_sel = 3'd0; bus.pc_write = 1'b1;
        step();
        src_s[0] = 32'h500; load_src();
        bus.exc_req = 1'b1; bus.exc_code = 2'd1;
        step();
        check("t4_pc_kept", bus.pc_out, 32'h104);
        check("t4_busy1", {31'd0, bus.exc_busy}, 32'd1);
        bus.exc_req = 1'b0;
        step();
        check("t4_epc", bus.epc_out, 32'h100);
        check("t4_busy2", {31'd0, bus.exc_busy}, 32'd1);
        step();
        check("t4_vector", bus.pc_out, 32'hFE);
        check("t4_busy_drop", {31'd0, bus.exc_busy}, 32'd0);

        // T5: return from exception via the EPC slot
        bus.pc_src_sel = 3'd4;
        step();
        check("t5_return", bus.pc_out, 32'h100);

        // T6: EPC wrap below zero
        src_s[0] = 32'h0; load_src(); bus.pc_src_sel = 3'd0;
        step();
        bus.pc_write = 1'b0; bus.exc_req = 1'b1; bus.exc_code = 2'd3;
        step();
        bus.exc_req = 1'b0;
        step();
        check("t6_wrap", bus.epc_out, 32'hFFFF_FFFC);
        step();
        check("t6_vec3", bus.pc_out, 32'h100);

        // T6: reset during SAVE aborts the sequence
        bus.exc_req = 1'b1;
        step();
        bus.exc_req = 1'b0; reset = 1'b1;
        step();
        check("t6_rst_epc", bus.epc_out, 32'h0);
        check("t6_rst_pc", bus.pc_out, 32'h0);
        reset = 1'b0;
        src_s[0] = 32'h44; load_src(); bus.pc_write = 1'b1;
        step();
        check("t6_idle_after_rst", bus.pc_out, 32'h44);

        // Back-to-back exceptions with exc_req held
        bus.exc_req = 1'b1; bus.exc_code = 2'd2;
        for (int i = 0; i < 7; i++) step();
        bus.exc_req = 1'b0;

        // Random stimulus
        for (int i = 0; i < 600; i++) begin
            for (int s = 0; s < 4; s++) src_s[s] = $urandom;
            load_src();
            bus.pc_src_sel    = 3'($urandom_range(0, 7));
            bus.pc_write      = 1'($urandom_range(0, 1));
            bus.pc_write_cond = 1'($urandom_range(0, 1));
            bus.branch_mode   = 2'($urandom_range(0, 3));
            bus.alu_zero      = 1'($urandom_range(0, 1));
            bus.alu_gt        = 1'($urandom_range(0, 1));
            bus.exc_req       = ($urandom_range(0, 5) == 0);
            bus.exc_code      = 2'($urandom_range(0, 3));
            reset             = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
